// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam logic [7:0] DEF_RST_PAT = 8'b0000_1010;
    localparam int DEF_RST_LEN = 4;

    // Length fields must hold 0..pat_w inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Bus bundle for seq_det_prog: configuration, serial input and detector outputs.
interface seq_det_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int LEN_W = len_w(PAT_W);

    // in_valid qualifies in_bit on each rising edge; there is no backpressure,
    // every qualified bit is consumed. cfg_we wins over in_valid on the same edge.
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_overlap;
    logic              in_valid;
    logic              in_bit;
    logic              match;
    logic [CNT_W-1:0]  match_count;
    logic              active;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        input  match, match_count, active
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        output match, match_count, active
    );

endinterface

// File: rtl/seq_det_cmp.sv
// Combinational masked compare of the low len bits of history against the pattern.
module seq_det_cmp #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic [PAT_W-1:0] hist_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             eq_o
);

    logic [PAT_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
    end

    assign eq_o = (((hist_i ^ pattern_i) & mask) == '0);

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector with overlap/non-overlap modes.
// Optional saturating match counter built when SEQ_DET_COUNT_EN is defined.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               RST_LEN = DEF_RST_LEN,
    parameter bit               RST_OVL = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    seq_det_if.slave bus,
    output state_t   dbg_state_o
);

    localparam int LEN_W = len_w(PAT_W);
    localparam logic [LEN_W-1:0] RST_LEN_C =
        (RST_LEN > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(RST_LEN);
    localparam state_t RST_STATE = (RST_LEN_C == '0) ? ST_IDLE : ST_FILL;

    state_t           state_q;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic             match_q;

    logic [PAT_W-1:0] hist_d;
    logic [LEN_W-1:0] fill_d;
    logic [LEN_W-1:0] cfg_len_c;
    logic             accept;
    logic             eq;
    logic             hit;

    // Oversized lengths behave as the full pattern width.
    assign cfg_len_c = (int'(bus.cfg_len) > PAT_W) ? LEN_W'(PAT_W) : bus.cfg_len;

    assign accept = bus.in_valid && !bus.cfg_we && (state_q != ST_IDLE);
    assign hist_d = {hist_q[PAT_W-2:0], bus.in_bit};
    assign fill_d = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;

    seq_det_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist_i    (hist_d),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .eq_o      (eq)
    );

    assign hit = accept && (fill_d == len_q) && eq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RST_STATE;
            pattern_q <= RST_PAT;
            len_q     <= RST_LEN_C;
            ovl_q     <= RST_OVL;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (bus.cfg_we) begin
            state_q   <= (cfg_len_c == '0) ? ST_IDLE : ST_FILL;
            pattern_q <= bus.cfg_pattern;
            len_q     <= cfg_len_c;
            ovl_q     <= bus.cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (accept) begin
            hist_q  <= hist_d;
            match_q <= hit;
            // Non-overlap restarts the fill so old history cannot contribute.
            if (hit && !ovl_q) begin
                fill_q  <= '0;
                state_q <= ST_FILL;
            end else begin
                fill_q  <= fill_d;
                state_q <= (fill_d == len_q) ? ST_HUNT : ST_FILL;
            end
        end else begin
            match_q <= 1'b0;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.cfg_we) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_count = cnt_q;
`else
    assign bus.match_count = '0;
`endif

    assign bus.match    = match_q;
    assign bus.active   = (len_q != '0);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog; a second CNT_W=2 instance
// shares the stimulus to exercise counter saturation.
module tb_seq_det_prog;
    import seq_det_pkg::*;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic   clk;
    logic   rst;
    state_t dbg_state;
    state_t dbg_state2;
    int     n_checks;
    int     n_errors;

    seq_det_if #(.PAT_W(8), .CNT_W(8)) bus ();
    seq_det_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

    assign bus2.cfg_we      = bus.cfg_we;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_overlap = bus.cfg_overlap;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_bit      = bus.in_bit;

    seq_det_prog #(.PAT_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    seq_det_prog #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus2),
        .dbg_state_o (dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int exp_cnt(input int n);
        return CNT_EN ? n : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic bubble();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check("bubble_match", bus.match, 1'b0);
    endtask

    // bits sent MSB first; exp bit aligned with each sent bit
    task automatic send_seq(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i]);
            check($sformatf("%s[%0d]", tag, i), bus.match, exp[n-1-i]);
            if (bubbles && i != n - 1) bubble();
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        @(negedge clk);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.in_valid    = 1'b1;
        bus.in_bit      = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_bit      = 1'b0;

        // reset defaults
        repeat (2) @(posedge clk);
        #1;
        check("rst_match", bus.match, 1'b0);
        check("rst_count", bus.match_count, 0);
        check("rst_active", bus.active, 1'b1);
        check("rst_state", dbg_state, ST_FILL);
        @(negedge clk);
        rst = 1'b1;

        // default 1010 overlap
        send_seq("dflt", 16'b101010, 6, 16'b000101, 1'b0);
        check("dflt_count", bus.match_count, exp_cnt(2));
        check("dflt_state", dbg_state, ST_HUNT);

        // non-overlap
        cfg(8'b1010, 4'd4, 1'b0);
        check("cfg_count_clr", bus.match_count, 0);
        check("cfg_state", dbg_state, ST_FILL);
        check("cfg_match_clr", bus.match, 1'b0);
        send_seq("novl", 16'b10101010, 8, 16'b00010001, 1'b0);
        check("novl_count", bus.match_count, exp_cnt(2));

        // 110 len 3, plain then with bubbles
        cfg(8'b110, 4'd3, 1'b1);
        send_seq("p110", 16'b1110, 4, 16'b0001, 1'b0);
        cfg(8'b110, 4'd3, 1'b1);
        send_seq("p110_bub", 16'b1110, 4, 16'b0001, 1'b1);
        check("p110_count", bus.match_count, exp_cnt(1));

        // cfg_we mid-stream discards partial history
        cfg(8'b1010, 4'd4, 1'b1);
        send_seq("part", 16'b101, 3, 16'b000, 1'b0);
        cfg(8'b1010, 4'd4, 1'b1);
        send_seq("part_after", 16'b0, 1, 16'b0, 1'b0);

        // disabled
        cfg(8'b1010, 4'd0, 1'b1);
        check("dis_active", bus.active, 1'b0);
        check("dis_state", dbg_state, ST_IDLE);
        send_seq("dis", 16'b10101010, 8, 16'b0, 1'b0);
        check("dis_count", bus.match_count, 0);

        // len 1 back-to-back
        cfg(8'b1, 4'd1, 1'b1);
        send_seq("len1", 16'b1101, 4, 16'b1101, 1'b0);
        check("len1_count", bus.match_count, exp_cnt(3));

        // oversized length clamps to full width
        cfg(8'hA5, 4'd15, 1'b1);
        send_seq("clamp", 16'b10100101, 8, 16'b00000001, 1'b0);

        // reset mid-stream, overriding cfg_we and in_valid
        cfg(8'b1010, 4'd4, 1'b1);
        send_seq("pre_rst", 16'b101, 3, 16'b000, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_len  = 4'd0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("inrst_match[%0d]", i), bus.match, 1'b0);
            check($sformatf("inrst_count[%0d]", i), bus.match_count, 0);
            check($sformatf("inrst_active[%0d]", i), bus.active, 1'b1);
            check($sformatf("inrst_state[%0d]", i), dbg_state, ST_FILL);
        end
        @(negedge clk);
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.in_valid = 1'b0;
        send_seq("post_rst", 16'b01010, 5, 16'b00001, 1'b0);

        // saturation on the CNT_W=2 instance
        cfg(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            check($sformatf("sat_match2[%0d]", i), bus2.match, 1'b1);
        end
        check("sat_count8", bus.match_count, exp_cnt(5));
        check("sat_count2", bus2.match_count, exp_cnt(3));
        bubble();
        check("sat_hold2", bus2.match_count, exp_cnt(3));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
